// File: rtl/dom_and_scheduler_pkg.sv
// Shared definitions for the masked-AND scheduler: FSM encoding, legal
// GAP settings and the requester-index width helper.
package dom_and_scheduler_pkg;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_GAP   = 1'b1
  } state_e;

  localparam int GAP_NONE = 0;
  localparam int GAP_ONE  = 1;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TAG_W_DEF = tag_w(N_DEF);

endpackage

// File: rtl/dom_and_scheduler_if.sv
// Request/operand/response bundle between the requesters and the scheduler.
interface dom_and_scheduler_if #(
  parameter int N = 4,
  parameter int W = 8
);

  logic [N-1:0]   req;
  logic [N*W-1:0] a0;
  logic [N*W-1:0] a1;
  logic [N*W-1:0] b0;
  logic [N*W-1:0] b1;
  logic [W-1:0]   z;
  logic           z_valid;
  logic           z_ack;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   q0;
  logic [W-1:0]   q1;
  logic           busy;

  modport master (
    output req, a0, a1, b0, b1, z, z_valid,
    input  z_ack, gnt, rsp_valid, q0, q1, busy
  );

  modport slave (
    input  req, a0, a1, b0, b1, z, z_valid,
    output z_ack, gnt, rsp_valid, q0, q1, busy
  );

endinterface

// File: rtl/dom_and_unit.sv
// Two-share domain-oriented-masking AND gate, two register stages.
// Shares are only ever combined across domains through the fresh mask z.
module dom_and_unit #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en1_i,
  input  logic         en2_i,
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] b0_i,
  input  logic [W-1:0] b1_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] q0_o,
  output logic [W-1:0] q1_o
);

  logic [W-1:0] p00_d, p11_d, p01_d, p10_d;
  logic [W-1:0] p00_q, p11_q, p01_q, p10_q;
  logic [W-1:0] q0_d, q1_d;
  logic [W-1:0] q0_q, q1_q;

  // Cross-domain products are re-masked before they are registered.
  assign p00_d = a0_i & b0_i;
  assign p11_d = a1_i & b1_i;
  assign p01_d = (a0_i & b1_i) ^ z_i;
  assign p10_d = (a1_i & b0_i) ^ z_i;

  assign q0_d = p00_q ^ p01_q;
  assign q1_d = p11_q ^ p10_q;

  // NOTE: every stage register is cleared on reset, not just the control bits,
  // so no share material from before reset can reappear on q0/q1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p00_q <= '0;
      p11_q <= '0;
      p01_q <= '0;
      p10_q <= '0;
      q0_q  <= '0;
      q1_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (en1_i) begin
        p00_q <= p00_d;
        p11_q <= p11_d;
        p01_q <= p01_d;
        p10_q <= p10_d;
      end
      if (en2_i) begin
        q0_q <= q0_d;
        q1_q <= q1_d;
      end
    end
  end

  assign q0_o = q0_q;
  assign q1_o = q1_q;

endmodule

// File: rtl/dom_and_scheduler.sv
// Round-robin scheduler sharing one masked AND unit among N requesters,
// with an optional forced idle cycle between issues and a 2-deep tag pipeline.
module dom_and_scheduler
  import dom_and_scheduler_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int GAP = GAP_ONE
) (
  input  logic                C,
  input  logic                R,
  dom_and_scheduler_if.slave  bus
);

  localparam int TAG_W = tag_w(N);

  state_e           state_q, state_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] winner;
  logic             found;
  logic             issue;

  logic             v1_q, v2_q;
  logic [TAG_W-1:0] tag1_q, tag2_q;

  logic [W-1:0]     a0_sel, a1_sel, b0_sel, b1_sel;

  // NOTE: every variable gets a default at the top of the block, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    logic [TAG_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = TAG_W'((int'(ptr_q) + i) % N);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign issue = !R && (state_q == ST_ISSUE) && found && bus.z_valid;

  // Only the winner's shares are steered into the unit; shares stay separate.
  always_comb begin
    a0_sel = '0;
    a1_sel = '0;
    b0_sel = '0;
    b1_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == TAG_W'(i)) begin
        a0_sel = bus.a0[i*W +: W];
        a1_sel = bus.a1[i*W +: W];
        b0_sel = bus.b0[i*W +: W];
        b1_sel = bus.b1[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_ISSUE: if (issue && GAP == GAP_ONE) state_d = ST_GAP;
      ST_GAP:   state_d = ST_ISSUE;
      default:  state_d = ST_ISSUE;
    endcase
    if (issue) begin
      ptr_d = (winner == TAG_W'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_ISSUE;
      ptr_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      tag1_q  <= '0;
      tag2_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      v1_q    <= issue;
      v2_q    <= v1_q;
      if (issue) tag1_q <= winner;
      if (v1_q)  tag2_q <= tag1_q;
    end
  end

  assign bus.gnt       = issue ? (N'(1) << winner) : '0;
  assign bus.z_ack     = issue;
  assign bus.rsp_valid = (!R && v2_q) ? (N'(1) << tag2_q) : '0;
  assign bus.busy      = !R && (v1_q || v2_q);

  // Stage 2 only advances behind a valid stage 1, so q0/q1 hold between results.
  dom_and_unit #(.W(W)) u_unit (
    .clk_i (C),
    .rst_i (R),
    .en1_i (issue),
    .en2_i (v1_q),
    .a0_i  (a0_sel),
    .a1_i  (a1_sel),
    .b0_i  (b0_sel),
    .b1_i  (b1_sel),
    .z_i   (bus.z),
    .q0_o  (bus.q0),
    .q1_o  (bus.q1)
  );

endmodule

// File: tb/tb_dom_and_scheduler.sv
// Directed bench: one GAP=0 and one GAP=1 instance, hand-computed expectations.
module tb_dom_and_scheduler;
  import dom_and_scheduler_pkg::*;

  logic C;
  logic R;
  int   n_cmp;
  int   n_err;

  dom_and_scheduler_if #(.N(4), .W(8)) bus0 ();
  dom_and_scheduler_if #(.N(4), .W(8)) bus1 ();

  dom_and_scheduler #(.N(4), .W(8), .GAP(GAP_NONE)) dut0 (.C(C), .R(R), .bus(bus0));
  dom_and_scheduler #(.N(4), .W(8), .GAP(GAP_ONE))  dut1 (.C(C), .R(R), .bus(bus1));

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge C);
    #1;
  endtask

  // Stream vectors for requester 0; vector 0 is the hand-worked 8'h14 case.
  logic [7:0] va0 [6] = '{8'h5A, 8'hFF, 8'h12, 8'h00, 8'h81, 8'hC3};
  logic [7:0] va1 [6] = '{8'h0F, 8'h00, 8'h34, 8'h00, 8'h7E, 8'h3C};
  logic [7:0] vb0 [6] = '{8'hC3, 8'hFF, 8'h56, 8'hFF, 8'hF0, 8'hAA};
  logic [7:0] vb1 [6] = '{8'hFF, 8'h00, 8'h78, 8'hFF, 8'h0F, 8'h00};
  logic [7:0] vz  [6] = '{8'h96, 8'h00, 8'hA5, 8'hFF, 8'h5A, 8'h11};
  logic [7:0] exp_and [6];

  // GAP=1, req=1111: grant 0,1,2,3,0 on even cycles, results two cycles later.
  logic [3:0] gap_gnt [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};
  logic [3:0] gap_rsp [9] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010,
                              4'b0000, 4'b0100, 4'b0000, 4'b1000};

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < 6; k++) exp_and[k] = (va0[k] ^ va1[k]) & (vb0[k] ^ vb1[k]);

    // Reset with a live request to show gating of all outputs.
    R = 1'b1;
    bus0.req = 4'b0001; bus0.z_valid = 1'b1; bus0.z = 8'h00;
    bus0.a0 = '0; bus0.a1 = '0; bus0.b0 = '0; bus0.b1 = '0;
    bus1.req = 4'b0000; bus1.z_valid = 1'b0; bus1.z = 8'h00;
    bus1.a0 = '0; bus1.a1 = '0; bus1.b0 = '0; bus1.b1 = '0;
    next_cycle();
    next_cycle();
    @(negedge C);
    check("rst_gnt",  bus0.gnt, 4'b0000);
    check("rst_zack", bus0.z_ack, 1'b0);
    check("rst_rsp",  bus0.rsp_valid, 4'b0000);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_q0",   bus0.q0, 8'h00);
    check("rst_q1",   bus0.q1, 8'h00);
    next_cycle();
    R = 1'b0;
    bus0.req = 4'b0000; bus0.z_valid = 1'b0;

    // Single requester streaming every cycle (GAP=0).
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (k < 6) begin
        bus0.req = 4'b0001; bus0.z_valid = 1'b1; bus0.z = vz[k];
        bus0.a0 = {24'hFFFFFF, va0[k]}; bus0.a1 = {24'h00FF00, va1[k]};
        bus0.b0 = {24'hFFFFFF, vb0[k]}; bus0.b1 = {24'hA5A5A5, vb1[k]};
      end else begin
        bus0.req = 4'b0000; bus0.z_valid = 1'b0;
      end
      @(negedge C);
      check("s_gnt",  bus0.gnt,   (k < 6) ? 4'b0001 : 4'b0000);
      check("s_zack", bus0.z_ack, (k < 6) ? 1'b1 : 1'b0);
      check("s_busy", bus0.busy,  (k >= 1) ? 1'b1 : 1'b0);
      if (k >= 2) begin
        check("s_rsp", bus0.rsp_valid, 4'b0001);
        check("s_and", bus0.q0 ^ bus0.q1, exp_and[k-2]);
      end else begin
        check("s_rsp0", bus0.rsp_valid, 4'b0000);
      end
      if (k == 2) check("and_14", bus0.q0 ^ bus0.q1, 8'h14);
    end
    next_cycle();
    @(negedge C);
    check("hold_rsp",  bus0.rsp_valid, 4'b0000);
    check("hold_busy", bus0.busy, 1'b0);
    check("hold_and",  bus0.q0 ^ bus0.q1, exp_and[5]);

    // Randomness stall: requester 1 waits 5 cycles for z_valid.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      bus0.req = 4'b0010;
      bus0.z_valid = (k == 5);
      @(negedge C);
      check("st_gnt",  bus0.gnt,   (k == 5) ? 4'b0010 : 4'b0000);
      check("st_zack", bus0.z_ack, (k == 5) ? 1'b1 : 1'b0);
    end
    next_cycle();
    bus0.req = 4'b0000; bus0.z_valid = 1'b0;
    repeat (3) next_cycle();

    // Wrap-around: grant 2 moves ptr to 3, then req=1001 grants 3 then 0.
    bus0.req = 4'b0100; bus0.z_valid = 1'b1;
    @(negedge C);
    check("w_gnt2", bus0.gnt, 4'b0100);
    next_cycle();
    bus0.req = 4'b1001;
    @(negedge C);
    check("w_gnt3", bus0.gnt, 4'b1000);
    next_cycle();
    @(negedge C);
    check("w_gnt0", bus0.gnt, 4'b0001);
    next_cycle();
    bus0.req = 4'b0000; bus0.z_valid = 1'b0;
    repeat (3) next_cycle();

    // Reset right after an issue: pointer 3 before reset, 0 after.
    bus0.req = 4'b0100; bus0.z_valid = 1'b1;
    @(negedge C);
    check("r_gnt2", bus0.gnt, 4'b0100);
    next_cycle();
    R = 1'b1;
    bus0.req = 4'b0000; bus0.z_valid = 1'b0;
    @(negedge C);
    check("r_busy_in", bus0.busy, 1'b0);
    next_cycle();
    R = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge C);
      check("r_rsp",  bus0.rsp_valid, 4'b0000);
      check("r_busy", bus0.busy, 1'b0);
      next_cycle();
    end
    bus0.req = 4'b1110; bus0.z_valid = 1'b1;
    @(negedge C);
    check("r_ptr0", bus0.gnt, 4'b0010);
    next_cycle();
    bus0.req = 4'b0000; bus0.z_valid = 1'b0;

    // GAP=1 instance, everyone requesting.
    for (int k = 0; k < 9; k++) begin
      bus1.req = 4'b1111; bus1.z_valid = 1'b1;
      @(negedge C);
      check("g_gnt",  bus1.gnt, gap_gnt[k]);
      check("g_zack", bus1.z_ack, (gap_gnt[k] != 4'b0000));
      check("g_rsp",  bus1.rsp_valid, gap_rsp[k]);
      next_cycle();
    end
    bus1.req = 4'b0000; bus1.z_valid = 1'b0;
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
